// File: rtl/alarm_bank.sv
// alarm_bank: NUM_ALARMS settable alarm channels with arming, time-match detection, timed ringing and dismiss.
// Snooze (SNOOZED state plus snooze counter) is compiled in only when ALARM_SNOOZE_EN is defined.
//   state   | meaning
//   IDLE    | not ringing; waits for an armed time match on SEC_TICK
//   RINGING | ringing; ring counter runs down on SEC_TICK
//   SNOOZED | silenced by SNOOZE; snooze counter runs down, then rings again
module alarm_bank #(
    parameter int NUM_ALARMS     = 4,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5,
    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  INCREMENT,
    input  logic                  DECREMENT,
    input  logic [1:0]            ORDER,
    input  logic [SEL_W-1:0]      SEL,
    input  logic [7:0]            CUR_SECONDS,
    input  logic [7:0]            CUR_MINUTES,
    input  logic [7:0]            CUR_HOURS,
    input  logic                  SEC_TICK,
    input  logic                  DISMISS,
    input  logic                  SNOOZE,
    output logic [7:0]            seconds,
    output logic [7:0]            minutes,
    output logic [7:0]            hours,
    output logic [NUM_ALARMS-1:0] armed,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic                  alarm
);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1, SNOOZED = 2'd2} state_t;
    localparam logic [11:0] SNZ_LOAD = 12'(SNOOZE_MINUTES * 60);
    logic        snz_q;
    logic        snz_ev;
    logic [11:0] snz_cnt [NUM_ALARMS];
    assign snz_ev = SNOOZE & ~snz_q;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1} state_t;
    localparam int unused_snooze_len = SNOOZE_MINUTES;
    logic unused_snooze;
    assign unused_snooze = SNOOZE;
`endif

    localparam logic [7:0] RING_LOAD = 8'(RING_SECONDS);

    logic [7:0] sec_r    [NUM_ALARMS];
    logic [7:0] min_r    [NUM_ALARMS];
    logic [7:0] hr_r     [NUM_ALARMS];
    logic [7:0] ring_cnt [NUM_ALARMS];
    state_t     state    [NUM_ALARMS];

    logic inc_q, dec_q, dis_q;
    logic inc_ev, dec_ev, dis_ev, edit_ev, sel_ok;
    logic [NUM_ALARMS-1:0] hit, disarm;

    assign inc_ev  = INCREMENT & ~inc_q;
    assign dec_ev  = DECREMENT & ~dec_q;
    assign dis_ev  = DISMISS & ~dis_q;
    assign edit_ev = inc_ev ^ dec_ev;
    assign sel_ok  = int'(SEL) < NUM_ALARMS;
    assign alarm   = |ringing;

    function automatic logic [7:0] step_field(input logic [7:0] v, input logic up,
                                              input logic [7:0] top);
        if (up) return (v >= top) ? 8'd0 : v + 8'd1;
        return (v == 8'd0 || v > top) ? top : v - 8'd1;
    endfunction

    // Match and disarm use pre-edge arm flags; a disarm overrides any ring transition.
    always_comb begin
        hit     = '0;
        disarm  = '0;
        ringing = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            hit[i]     = SEC_TICK && armed[i] && (CUR_SECONDS == sec_r[i]) &&
                         (CUR_MINUTES == min_r[i]) && (CUR_HOURS == hr_r[i]);
            disarm[i]  = sel_ok && (i == int'(SEL)) && (ORDER == 2'b11) && edit_ev &&
                         (dec_ev || armed[i]);
            ringing[i] = (state[i] == RINGING);
        end
    end

    always_comb begin
        seconds = '0;
        minutes = '0;
        hours   = '0;
        if (sel_ok) begin
            seconds = sec_r[SEL];
            minutes = min_r[SEL];
            hours   = hr_r[SEL];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            dis_q <= 1'b0;
            armed <= '0;
`ifdef ALARM_SNOOZE_EN
            snz_q <= 1'b0;
`endif
            for (int i = 0; i < NUM_ALARMS; i++) begin
                sec_r[i]    <= '0;
                min_r[i]    <= '0;
                hr_r[i]     <= '0;
                ring_cnt[i] <= '0;
                state[i]    <= IDLE;
`ifdef ALARM_SNOOZE_EN
                snz_cnt[i]  <= '0;
`endif
            end
        end else begin
            inc_q <= INCREMENT;
            dec_q <= DECREMENT;
            dis_q <= DISMISS;
`ifdef ALARM_SNOOZE_EN
            snz_q <= SNOOZE;
`endif
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (sel_ok && (i == int'(SEL)) && edit_ev) begin
                    case (ORDER)
                        2'b00:   sec_r[i] <= step_field(sec_r[i], inc_ev, 8'd59);
                        2'b01:   min_r[i] <= step_field(min_r[i], inc_ev, 8'd59);
                        2'b10:   hr_r[i]  <= step_field(hr_r[i], inc_ev, 8'd23);
                        default: armed[i] <= inc_ev ? ~armed[i] : 1'b0;
                    endcase
                end

                if (disarm[i]) begin
                    state[i] <= IDLE;
                end else begin
                    case (state[i])
                        IDLE: begin
                            if (hit[i]) begin
                                state[i]    <= RINGING;
                                ring_cnt[i] <= RING_LOAD;
                            end
                        end
                        RINGING: begin
                            if (dis_ev) begin
                                state[i] <= IDLE;
`ifdef ALARM_SNOOZE_EN
                            end else if (snz_ev) begin
                                state[i]   <= SNOOZED;
                                snz_cnt[i] <= SNZ_LOAD;
`endif
                            end else if (SEC_TICK) begin
                                if (ring_cnt[i] <= 8'd1) state[i] <= IDLE;
                                else ring_cnt[i] <= ring_cnt[i] - 8'd1;
                            end
                        end
`ifdef ALARM_SNOOZE_EN
                        SNOOZED: begin
                            if (dis_ev) begin
                                state[i] <= IDLE;
                            end else if (SEC_TICK) begin
                                if (snz_cnt[i] <= 12'd1) begin
                                    state[i]    <= RINGING;
                                    ring_cnt[i] <= RING_LOAD;
                                end else begin
                                    snz_cnt[i] <= snz_cnt[i] - 12'd1;
                                end
                            end
                        end
`endif
                        default: state[i] <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Bench for alarm_bank: directed test-plan checks with literal expectations, then randomized
// stimulus compared every cycle against a behavioural model based on remaining-time counts.
module tb_alarm_bank;
    localparam int N       = 4;
    localparam int RING    = 3;
    localparam int SNZ_MIN = 1;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNOOZE_ON = 1'b1;
`else
    localparam bit SNOOZE_ON = 1'b0;
`endif

    logic       CLK, RESET, INCREMENT, DECREMENT, SEC_TICK, DISMISS, SNOOZE;
    logic [1:0] ORDER, SEL;
    logic [7:0] CUR_SECONDS, CUR_MINUTES, CUR_HOURS;
    logic [7:0] seconds, minutes, hours;
    logic [N-1:0] armed, ringing;
    logic       alarm;

    alarm_bank #(.NUM_ALARMS(N), .RING_SECONDS(RING), .SNOOZE_MINUTES(SNZ_MIN)) dut (
        .CLK(CLK), .RESET(RESET), .INCREMENT(INCREMENT), .DECREMENT(DECREMENT),
        .ORDER(ORDER), .SEL(SEL), .CUR_SECONDS(CUR_SECONDS), .CUR_MINUTES(CUR_MINUTES),
        .CUR_HOURS(CUR_HOURS), .SEC_TICK(SEC_TICK), .DISMISS(DISMISS), .SNOOZE(SNOOZE),
        .seconds(seconds), .minutes(minutes), .hours(hours), .armed(armed),
        .ringing(ringing), .alarm(alarm)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a channel rings while m_ring > 0 (seconds left) and is snoozed while m_snz > 0.
    int m_sec [N], m_min [N], m_hr [N], m_ring [N], m_snz [N];
    bit m_armed [N];
    bit p_inc, p_dec, p_dis, p_snz;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sec[i] = 0; m_min[i] = 0; m_hr[i] = 0;
            m_ring[i] = 0; m_snz[i] = 0; m_armed[i] = 0;
        end
        p_inc = 0; p_dec = 0; p_dis = 0; p_snz = 0;
    endtask

    task automatic model_step();
        bit ie, de, dse, sne, ed;
        int s;
        ie  = INCREMENT && !p_inc;
        de  = DECREMENT && !p_dec;
        dse = DISMISS && !p_dis;
        sne = SNOOZE && !p_snz;
        p_inc = INCREMENT; p_dec = DECREMENT; p_dis = DISMISS; p_snz = SNOOZE;
        ed = (ie != de);
        s  = int'(SEL);
        for (int i = 0; i < N; i++) begin
            bit hit, off;
            hit = SEC_TICK && m_armed[i] && (int'(CUR_SECONDS) == m_sec[i]) &&
                  (int'(CUR_MINUTES) == m_min[i]) && (int'(CUR_HOURS) == m_hr[i]);
            off = (s == i) && (ORDER == 2'b11) && ed && (de || m_armed[i]);
            if (off) begin
                m_ring[i] = 0; m_snz[i] = 0;
            end else if (m_ring[i] > 0) begin
                if (dse) m_ring[i] = 0;
                else if (SNOOZE_ON && sne) begin m_ring[i] = 0; m_snz[i] = SNZ_MIN * 60; end
                else if (SEC_TICK) m_ring[i] = m_ring[i] - 1;
            end else if (m_snz[i] > 0) begin
                if (dse) m_snz[i] = 0;
                else if (SEC_TICK) begin
                    m_snz[i] = m_snz[i] - 1;
                    if (m_snz[i] == 0) m_ring[i] = RING;
                end
            end else if (hit) begin
                m_ring[i] = RING;
            end
        end
        if (ed) begin
            case (ORDER)
                2'b00:   m_sec[s] = (m_sec[s] + (ie ? 1 : 59)) % 60;
                2'b01:   m_min[s] = (m_min[s] + (ie ? 1 : 59)) % 60;
                2'b10:   m_hr[s]  = (m_hr[s] + (ie ? 1 : 23)) % 24;
                default: m_armed[s] = ie ? !m_armed[s] : 1'b0;
            endcase
        end
    endtask

    function automatic logic [N-1:0] ring_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (m_ring[i] > 0);
        return v;
    endfunction

    function automatic logic [N-1:0] arm_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_armed[i];
        return v;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RESET);
            if (!RESET) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            check("outputs", {seconds, minutes, hours, armed, ringing, alarm},
                  {8'(m_sec[SEL]), 8'(m_min[SEL]), 8'(m_hr[SEL]), arm_vec(), ring_vec(),
                   |ring_vec()});
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_inc(input int n);
        for (int k = 0; k < n; k++) begin
            INCREMENT = 1'b1; cyc(); INCREMENT = 1'b0; cyc();
        end
    endtask

    task automatic pulse_dec();
        DECREMENT = 1'b1; cyc(); DECREMENT = 1'b0; cyc();
    endtask

    task automatic pulse_dismiss();
        DISMISS = 1'b1; cyc(); DISMISS = 1'b0; cyc();
    endtask

    task automatic tick();
        SEC_TICK = 1'b1; cyc(); SEC_TICK = 1'b0;
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        CUR_HOURS = 8'(h); CUR_MINUTES = 8'(m); CUR_SECONDS = 8'(s);
    endtask

    initial begin
        int ch;
        RESET = 1'b0; INCREMENT = 0; DECREMENT = 0; SEC_TICK = 0; DISMISS = 0; SNOOZE = 0;
        ORDER = 2'b00; SEL = 2'd0;
        set_cur(0, 0, 0);
        repeat (3) cyc();
        RESET = 1'b1;
        cyc();

        for (int i = 0; i < N; i++) begin
            SEL = 2'(i); #1;
            check("reset_time", {seconds, minutes, hours}, 24'h0);
        end
        check("reset_armed", armed, 4'b0000);
        check("reset_alarm", {ringing, alarm}, 5'b0);

        SEL = 2'd2; ORDER = 2'b10;
        pulse_inc(25);
        check("hours_wrap_up", hours, 8'd1);
        pulse_dec();
        check("hours_dec", hours, 8'd0);
        pulse_dec();
        check("hours_wrap_down", hours, 8'd23);
        SEL = 2'd0; #1; check("other_ch0", hours, 8'd0);
        SEL = 2'd1; #1; check("other_ch1", hours, 8'd0);
        SEL = 2'd3; #1; check("other_ch3", hours, 8'd0);

        SEL = 2'd1; ORDER = 2'b10; pulse_inc(7);
        ORDER = 2'b01; pulse_inc(30);
        ORDER = 2'b11; pulse_inc(1);
        check("ch1_time", {hours, minutes, seconds}, {8'd7, 8'd30, 8'd0});
        check("ch1_armed", armed, 4'b0010);
        set_cur(7, 30, 0);
        tick();
        check("match_ring", {ringing, alarm}, {4'b0010, 1'b1});
        set_cur(7, 30, 1);
        cyc();
        tick(); tick();
        check("ring_still", ringing, 4'b0010);
        tick();
        check("ring_timeout", {ringing, alarm}, 5'b0);

        SEL = 2'd0; pulse_inc(1);
        SEL = 2'd3; pulse_inc(1);
        check("arm_03", armed, 4'b1011);
        set_cur(0, 0, 0);
        tick(); cyc();
        check("ring_03", ringing, 4'b1001);
        pulse_dismiss();
        check("dismiss", ringing, 4'b0000);
        check("dismiss_armed", armed, 4'b1011);
        tick(); cyc();
        check("rering_03", ringing, 4'b1001);
        SEL = 2'd3; ORDER = 2'b11;
        DECREMENT = 1'b1; cyc();
        check("disarm_drop", ringing, 4'b0001);
        check("disarm_flag", armed, 4'b0011);
        DECREMENT = 1'b0; cyc();
        pulse_dismiss();

        SEL = 2'd0; ORDER = 2'b00;
        INCREMENT = 1'b1; DECREMENT = 1'b1; cyc();
        check("inc_dec_same", seconds, 8'd0);
        INCREMENT = 1'b0; DECREMENT = 1'b0; cyc();
        INCREMENT = 1'b1; repeat (10) cyc();
        INCREMENT = 1'b0; cyc();
        check("held_inc", seconds, 8'd1);

        set_cur(0, 0, 1);
        tick();
        check("ring_ch0", ringing, 4'b0001);
        set_cur(0, 0, 2);
        cyc();
        SNOOZE = 1'b1; cyc();
`ifdef ALARM_SNOOZE_EN
        check("snooze_quiet", ringing, 4'b0000);
        SNOOZE = 1'b0; cyc();
        for (int k = 0; k < 59; k++) begin
            tick();
            check("snooze_hold", ringing, 4'b0000);
        end
        tick();
        check("snooze_end", ringing, 4'b0001);
        cyc();
        SNOOZE = 1'b0; cyc(); SNOOZE = 1'b1; cyc(); SNOOZE = 1'b0;
        tick(); tick();
`else
        check("snooze_ignored", ringing, 4'b0001);
        SNOOZE = 1'b0; cyc();
        tick();
`endif
        RESET = 1'b0; #1;
        check("reset_mid", {seconds, minutes, hours, armed, ringing, alarm}, 33'h0);
        cyc();
        RESET = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            cyc();
            INCREMENT = ($urandom_range(0, 3) == 0);
            DECREMENT = ($urandom_range(0, 4) == 0);
            ORDER     = 2'($urandom_range(0, 3));
            SEL       = 2'($urandom_range(0, 3));
            DISMISS   = ($urandom_range(0, 149) == 0);
            SNOOZE    = ($urandom_range(0, 39) == 0);
            SEC_TICK  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) begin
                ch = $urandom_range(0, N - 1);
                set_cur(m_hr[ch], m_min[ch], m_sec[ch]);
            end else begin
                set_cur($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3));
            end
            RESET = ($urandom_range(0, 799) != 0);
        end
        RESET = 1'b1;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alarm_bank.md
# alarm_bank

Parametrised bank of `NUM_ALARMS` independently settable alarm times with per-channel arming, time-match detection, timed ringing and dismiss. It is the successor to the single-alarm time register and sits beside the timekeeping counter. The bank takes current time and a one-second tick from that counter, and drives the display readback mux and the buzzer.

## Interface
Parameters:
- `NUM_ALARMS`, default 4: number of alarm channels, 1..16.
- `RING_SECONDS`, default 60: seconds an alarm rings before automatic timeout, 1..255.
- `SNOOZE_MINUTES`, default 5: snooze length in minutes, 1..59. Only used with `ALARM_SNOOZE_EN`.

Ports:
- `CLK` in 1: system clock.
- `RESET` in 1: asynchronous, active-low reset.
- `INCREMENT` in 1: set button, level input; acts on its rising edge.
- `DECREMENT` in 1: set button, level input; acts on its rising edge.
- `ORDER` in 2: field select. 00 = seconds, 01 = minutes, 10 = hours, 11 = arm control.
- `SEL` in `$clog2(NUM_ALARMS)` (min 1): channel being edited and read back.
- `CUR_SECONDS`, `CUR_MINUTES`, `CUR_HOURS` in 8 each: current time, binary.
- `SEC_TICK` in 1: one-cycle pulse when current time advances.
- `DISMISS` in 1: level input; acts on its rising edge.
- `SNOOZE` in 1: level input; acts on its rising edge. Ignored without `ALARM_SNOOZE_EN`.
- `seconds`, `minutes`, `hours` out 8 each: alarm time of channel `SEL`.
- `armed` out `NUM_ALARMS`: per-channel arm flags.
- `ringing` out `NUM_ALARMS`: per-channel ring state.
- `alarm` out 1: OR of `ringing`.

## Operation
- All inputs are synchronous to `CLK`; synchronisers live upstream.
- Edge detect: each button is registered; an event is `btn & ~btn_q`.
- Edit applies only to channel `SEL` when `SEL < NUM_ALARMS`; otherwise the edit is ignored.
- Field arithmetic:
  - Fields are independent, with no carry between them.
  - Seconds and minutes: +1 wraps 59→0; −1 wraps 0→59.
  - Hours: +1 wraps 23→0; −1 wraps 0→23.
  - INCREMENT and DECREMENT events in the same cycle: no change.
- `ORDER`=11: an INCREMENT event toggles `armed[SEL]`; a DECREMENT event clears it.
- Per-channel FSM:
  - IDLE→RINGING on `SEC_TICK` when the channel is armed and the current time equals the alarm time on all three fields. Ring counter loads `RING_SECONDS`.
  - RINGING: ring counter decrements on each `SEC_TICK`. Counter at 1 with a `SEC_TICK` → IDLE. A re-match while RINGING is ignored.
  - A DISMISS event sends every RINGING and SNOOZED channel to IDLE. Channels stay armed.
  - Disarming a channel forces it to IDLE.
  - Editing any field of a RINGING channel does not stop it.
- `ringing[i]` is 1 only in RINGING.
- Reset values: all fields 0, `armed` 0, all FSMs IDLE, counters 0, edge registers 0. Therefore `seconds`, `minutes`, `hours`, `ringing` and `alarm` are 0.
- `RESET` asserted mid-ring clears everything immediately.

## Timing
- A button event is detected at the first edge that samples the input high after it was sampled low. The field or arm flag is updated at that same edge and is visible on outputs after it.
- Readback outputs are a combinational mux of channel registers by `SEL`. They follow `SEL` in the same cycle.
- A match sampled with `SEL_TICK` at edge n means `ringing` and `alarm` are high after edge n.
- Ring duration is exactly `RING_SECONDS` `SEC_TICK` pulses, counting from the tick after the match tick.
- A DISMISS event takes effect at the detecting edge. If DISMISS and a new match occur in the same cycle, dismiss applies to channels already ringing. A newly matching IDLE channel still enters RINGING.

## Configuration
- `ALARM_SNOOZE_EN` defined:
  - A SNOOZE event moves every RINGING channel to SNOOZED and loads the snooze counter with `SNOOZE_MINUTES*60`. The counter is 12 bits.
  - SNOOZED decrements the counter on each `SEC_TICK`. At 1 with a tick, the channel returns to RINGING and the ring counter reloads `RING_SECONDS`.
  - DISMISS and SNOOZE events in the same cycle: DISMISS wins.
- `ALARM_SNOOZE_EN` undefined: the SNOOZED state and snooze counter are absent, the `SNOOZE` port exists but is unused, and behaviour is otherwise identical.

## Test plan
- Reset, then read back all channels → every field 0, `armed`=0, `alarm`=0.
- `SEL`=2, `ORDER`=10, 25 INCREMENT pulses → `hours`=1; one DECREMENT from 0 → `hours`=23. Channels 0, 1 and 3 remain 0.
- Channel 1 set to 07:30:00 and armed; drive current time 07:30:00 with `SEC_TICK` → `ringing`=0010 after that edge. With `RING_SECONDS`=3, three more ticks → `ringing`=0000.
- Channels 0 and 3 ringing, DISMISS pulse → `ringing`=0000, `armed` unchanged. Disarming a ringing channel also drops `ringing` next edge.
- INCREMENT and DECREMENT rising together → field unchanged. INCREMENT held high for 10 cycles → exactly +1.
- With `ALARM_SNOOZE_EN` and `SNOOZE_MINUTES`=1: SNOOZE during a ring → `ringing` low for exactly 60 ticks, then high. RESET mid-snooze → all outputs 0.
